sample_ram: RTL and testbench
=============================

# sample_ram

Parametrised simple-dual-port sample buffer for the audio datapath: one write port with byte enables, one independent read port with registered output and valid strobe. It replaces the single-port asynchronous-read RAM in sample/wavetable storage where the synthesis and playback engines must write and read in the same cycle. An optional post-reset clear sweep guarantees silence (all-zero samples) before first use.

## Interface
Parameters:
- DataWidth, 16, bits per word; must be a multiple of ByteWidth
- ByteWidth, 8, bits per byte-enable lane
- AddressWidth, 8, address bus width
- Depth, 256, number of words; Depth ≤ 2^AddressWidth

Ports:
- i_CLK  in  1  single clock; all logic on rising edge
- i_NRESET  in  1  reset, synchronous, active-low
- i_ENABLE  in  1  global enable; gates both user ports
- i_WE  in  1  write request
- i_WriteAddress  in  AddressWidth  write address
- i_WriteData  in  DataWidth  write data
- i_ByteEnable  in  DataWidth/ByteWidth  per-lane write enable, bit k → bits [k*ByteWidth +: ByteWidth]
- i_RE  in  1  read request
- i_ReadAddress  in  AddressWidth  read address
- o_ReadData  out  DataWidth  registered read data
- o_ReadValid  out  1  one-cycle strobe, o_ReadData valid
- o_Busy  out  1  clear sweep in progress; user ports ignored

## Operation
- Reset values: o_ReadData = 0, o_ReadValid = 0, o_Busy = 1 with clear enabled, 0 without; clear counter = 0; state = CLEAR (clear enabled) or READY.
- States: CLEAR → READY when counter == Depth-1 (that word written on the transition edge). READY holds until i_NRESET low. Reset in any state → CLEAR, counter 0 (restart).
- CLEAR: one word per cycle, counter 0..Depth-1, writes all-zero regardless of i_ENABLE; i_WE/i_RE ignored; o_ReadValid stays 0.
- READY write: accepted when i_ENABLE & i_WE; lanes with i_ByteEnable[k]=1 updated, others kept. i_ByteEnable = 0 is a no-op.
- READY read: accepted when i_ENABLE & i_RE; o_ReadData ← mem[i_ReadAddress], o_ReadValid ← 1 next cycle. No accept → o_ReadValid ← 0, o_ReadData holds.
- Read/write collision (same address, same cycle): write-first per lane — enabled lanes return new data, disabled lanes return old data.
- Out-of-range address (≥ Depth): write dropped; read accepted, returns 0, o_ReadValid asserted.
- i_ENABLE = 0 in READY: no write, no read accept; memory and o_ReadData preserved.
- Memory contents are not reset by i_NRESET except via clear sweep.

## Timing
- Write latency: data visible to a read issued the same cycle (bypass) and all later cycles.
- Read latency: 1 cycle, request at edge N → data and valid after edge N+1; back-to-back reads every cycle, full throughput.
- Clear duration: exactly Depth cycles after first edge with i_NRESET high; o_Busy falls after edge Depth; first read may be issued that cycle.
- o_Busy is decoded from registered state (no combinational path from inputs).

## Configuration
- SAMPLE_RAM_CLEAR_EN defined: CLEAR state, counter and sweep built; o_Busy behaves as above; memory reads 0 after every reset.
- Not defined: no counter, state fixed READY, o_Busy tied 0; ports usable first edge after reset release; contents uninitialised after power-up and preserved across reset.

## Structure
- Package sample_ram_pkg: state enum (CLEAR, READY), localparam helper for lane count DataWidth/ByteWidth, function building a DataWidth write mask from byte enables.
- Sub-module sample_ram_clear_ctrl: state register, clear counter, o_Busy, internal clear write address/enable; compiled only under SAMPLE_RAM_CLEAR_EN. Storage array, port muxing and bypass stay in sample_ram.

## Test plan
- Clear: reset 3 cycles, release → o_Busy high exactly 256 cycles; then read addresses 0, 128, 255 → 0x0000, o_ReadValid one cycle after each request.
- Write/read: write 0xBEEF to 0x10 (BE=11), read 0x10 next cycle → 0xBEEF after 1 cycle; back-to-back reads 0x10,0x11 → valid two consecutive cycles.
- Byte enables: write 0x1234 to 0x20, then 0xAB00 BE=10 → read 0xAB34; BE=00 write 0xFFFF → still 0xAB34.
- Collision: 0x30 holds 0x5555; same-cycle write 0xAAAA BE=01 and read 0x30 → 0x55AA.
- Gating/range: i_ENABLE=0 with i_WE, i_RE → no change, o_ReadValid 0; read address 300 with AddressWidth 9, Depth 256 → 0, valid 1; write there → no array change.
- Reset mid-clear: assert i_NRESET low at clear cycle 100 for 1 cycle → sweep restarts, o_Busy high 256 further cycles; in READY, requests during o_Busy ignored.

Source files
------------

// File: rtl/sample_ram_pkg.sv
// Shared types and helpers for the sample_ram audio buffer.
// Optional post-reset clear sweep is built when SAMPLE_RAM_CLEAR_EN is defined.
package sample_ram_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    // Widest word build_mask can handle; callers truncate to their own width.
    localparam int MaxDataWidth = 256;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic logic [MaxDataWidth-1:0] build_mask(
        input logic [MaxDataWidth-1:0] byte_enable,
        input int                      byte_width
    );
        logic [MaxDataWidth-1:0] mask;
        mask = '0;
        for (int i = 0; i < MaxDataWidth; i++) begin
            mask[i] = byte_enable[i / byte_width];
        end
        return mask;
    endfunction

endpackage

// File: rtl/sample_ram_clear_ctrl.sv
// Post-reset clear sequencer: sweeps every word to zero, then holds READY.
// Only instantiated when SAMPLE_RAM_CLEAR_EN is defined.
module sample_ram_clear_ctrl
    import sample_ram_pkg::*;
#(
    parameter int Depth    = 256,
    parameter int IdxWidth = 8
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    output logic                o_Busy,
    output logic                o_ClearWe,
    output logic [IdxWidth-1:0] o_ClearIndex
);

    state_t              state;
    logic [IdxWidth-1:0] count;

    // The last word is written on the same edge that moves the FSM to READY.
    always_ff @(posedge i_CLK) begin
        if (!i_NRESET) begin
            state <= CLEAR;
            count <= '0;
        end else if (state == CLEAR) begin
            if (count == IdxWidth'(Depth - 1)) begin
                state <= READY;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign o_Busy       = (state == CLEAR);
    assign o_ClearWe    = o_Busy && i_NRESET;
    assign o_ClearIndex = count;

endmodule

// File: rtl/sample_ram.sv
// Simple-dual-port sample buffer with byte enables, write-first bypass and registered read.
// Define SAMPLE_RAM_CLEAR_EN to build the post-reset zeroing sweep.
module sample_ram
    import sample_ram_pkg::*;
#(
    parameter int DataWidth    = 16,
    parameter int ByteWidth    = 8,
    parameter int AddressWidth = 8,
    parameter int Depth        = 256
) (
    input  logic                                        i_CLK,
    input  logic                                        i_NRESET,
    input  logic                                        i_ENABLE,
    input  logic                                        i_WE,
    input  logic [AddressWidth-1:0]                     i_WriteAddress,
    input  logic [DataWidth-1:0]                        i_WriteData,
    input  logic [lane_count(DataWidth, ByteWidth)-1:0] i_ByteEnable,
    input  logic                                        i_RE,
    input  logic [AddressWidth-1:0]                     i_ReadAddress,
    output logic [DataWidth-1:0]                        o_ReadData,
    output logic                                        o_ReadValid,
    output logic                                        o_Busy
);

    localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] mem [0:Depth-1];

    logic                ready;
    logic                clear_we;
    logic [IdxWidth-1:0] clear_idx;

`ifdef SAMPLE_RAM_CLEAR_EN
    sample_ram_clear_ctrl #(
        .Depth    (Depth),
        .IdxWidth (IdxWidth)
    ) u_clear_ctrl (
        .i_CLK        (i_CLK),
        .i_NRESET     (i_NRESET),
        .o_Busy       (o_Busy),
        .o_ClearWe    (clear_we),
        .o_ClearIndex (clear_idx)
    );
    assign ready = !o_Busy;
`else
    assign ready     = 1'b1;
    assign clear_we  = 1'b0;
    assign clear_idx = '0;
    assign o_Busy    = 1'b0;
`endif

    logic [IdxWidth-1:0]  waddr_idx;
    logic [IdxWidth-1:0]  raddr_idx;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [DataWidth-1:0] wr_mask;
    logic [DataWidth-1:0] wr_word;
    logic [DataWidth-1:0] rd_word;

    // Same-address read during a write sees the new lanes and the old untouched lanes.
    always_comb begin
        waddr_idx   = i_WriteAddress[IdxWidth-1:0];
        raddr_idx   = i_ReadAddress[IdxWidth-1:0];
        wr_in_range = 32'(i_WriteAddress) < Depth;
        rd_in_range = 32'(i_ReadAddress) < Depth;
        wr_accept   = i_NRESET && ready && i_ENABLE && i_WE && wr_in_range;
        rd_accept   = ready && i_ENABLE && i_RE;
        wr_mask     = DataWidth'(build_mask(MaxDataWidth'(i_ByteEnable), ByteWidth));
        wr_word     = (mem[waddr_idx] & ~wr_mask) | (i_WriteData & wr_mask);
        rd_word     = '0;
        if (rd_in_range) begin
            rd_word = mem[raddr_idx];
            if (wr_accept && (i_WriteAddress == i_ReadAddress)) begin
                rd_word = (rd_word & ~wr_mask) | (i_WriteData & wr_mask);
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (clear_we) begin
            mem[clear_idx] <= '0;
        end else if (wr_accept) begin
            mem[waddr_idx] <= wr_word;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_NRESET) begin
            o_ReadData  <= '0;
            o_ReadValid <= 1'b0;
        end else begin
            o_ReadValid <= rd_accept;
            if (rd_accept) begin
                o_ReadData <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sample_ram.sv
// Directed self-checking bench for sample_ram (AddressWidth 9, Depth 256).
// Clear-sweep checks are compiled when SAMPLE_RAM_CLEAR_EN is defined.
module tb_sample_ram;

    localparam int DW = 16;
    localparam int BW = 8;
    localparam int AW = 9;
    localparam int D  = 256;

`ifdef SAMPLE_RAM_CLEAR_EN
    localparam logic ClearEn = 1'b1;
`else
    localparam logic ClearEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset;
    logic          enable;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [1:0]    be;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int n;
    int bad;

    always #5 clk = ~clk;

    sample_ram #(
        .DataWidth    (DW),
        .ByteWidth    (BW),
        .AddressWidth (AW),
        .Depth        (D)
    ) dut (
        .i_CLK          (clk),
        .i_NRESET       (nreset),
        .i_ENABLE       (enable),
        .i_WE           (we),
        .i_WriteAddress (waddr),
        .i_WriteData    (wdata),
        .i_ByteEnable   (be),
        .i_RE           (re),
        .i_ReadAddress  (raddr),
        .o_ReadData     (rdata),
        .o_ReadValid    (rvalid),
        .o_Busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic w, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [1:0] b,
                                 input logic r, input logic [AW-1:0] ra);
        enable = en;
        we     = w;
        waddr  = wa;
        wdata  = wd;
        be     = b;
        re     = r;
        raddr  = ra;
        tick();
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] exp_data, input logic exp_valid);
        checks++;
        assert (rvalid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s valid: observed=%0b expected=%0b", tag, rvalid, exp_valid);
        end
        checks++;
        assert (rdata === exp_data) else begin
            errors++;
            $error("[TB] FAIL %s data: observed=0x%04h expected=0x%04h", tag, rdata, exp_data);
        end
    endtask

    task automatic checkBusy(input string tag, input logic exp_busy);
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed=%0b expected=%0b", tag, busy, exp_busy);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        nreset = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0);
        idle();
        idle();
        checkOutput("reset", 16'h0000, 1'b0);
        checkBusy("reset_busy", ClearEn);
        nreset = 1'b1;

`ifdef SAMPLE_RAM_CLEAR_EN
        repeat (100) idle();
        checkBusy("busy_at_100", 1'b1);
        nreset = 1'b0;
        idle();
        checkBusy("mid_reset_busy", 1'b1);
        checkOutput("mid_reset", 16'h0000, 1'b0);
        nreset = 1'b1;
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && n < 400) begin
            applyStimulus(1'b1, 1'b1, 9'd5, 16'hFFFF, 2'b11, 1'b1, 9'd5);
            n++;
            if (rvalid !== 1'b0) bad++;
        end
        checkCount("sweep_len", n, 256);
        checkCount("busy_valid_seen", bad, 0);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'd0);
        checkOutput("clr_0", 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'd128);
        checkOutput("clr_128", 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'd255);
        checkOutput("clr_255", 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'd5);
        checkOutput("clr_busy_write_dropped", 16'h0000, 1'b1);
        idle();
        checkOutput("clr_idle", 16'h0000, 1'b0);
`endif

        // basic write then read, back-to-back reads
        applyStimulus(1'b1, 1'b1, 9'h010, 16'hBEEF, 2'b11, 1'b0, '0);
        checkOutput("wr_only", 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h010);
        checkOutput("rd_10", 16'hBEEF, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'h011, 16'h1111, 2'b11, 1'b0, '0);
        checkOutput("wr_11_hold", 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h010);
        checkOutput("b2b_10", 16'hBEEF, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h011);
        checkOutput("b2b_11", 16'h1111, 1'b1);
        idle();
        checkOutput("b2b_idle", 16'h1111, 1'b0);

        // byte enables
        applyStimulus(1'b1, 1'b1, 9'h020, 16'h1234, 2'b11, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'h020, 16'hAB00, 2'b10, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h020);
        checkOutput("be_hi", 16'hAB34, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'h020, 16'hFFFF, 2'b00, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h020);
        checkOutput("be_none", 16'hAB34, 1'b1);

        // same-cycle read/write collision, write-first per lane
        applyStimulus(1'b1, 1'b1, 9'h030, 16'h5555, 2'b11, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'h030, 16'hAAAA, 2'b01, 1'b1, 9'h030);
        checkOutput("coll_lo", 16'h55AA, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h030);
        checkOutput("coll_lo_stored", 16'h55AA, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'h030, 16'h33CC, 2'b10, 1'b1, 9'h030);
        checkOutput("coll_hi", 16'h33AA, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'h040, 16'h7777, 2'b11, 1'b1, 9'h010);
        checkOutput("diff_addr_no_bypass", 16'hBEEF, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h040);
        checkOutput("rd_40", 16'h7777, 1'b1);

        // global enable gating
        applyStimulus(1'b0, 1'b1, 9'h030, 16'h0000, 2'b11, 1'b1, 9'h020);
        checkOutput("enable_low", 16'h7777, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h030);
        checkOutput("enable_low_no_write", 16'h33AA, 1'b1);

        // out-of-range addresses
        applyStimulus(1'b1, 1'b1, 9'h02C, 16'h4444, 2'b11, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'd300, 16'hDEAD, 2'b11, 1'b1, 9'd300);
        checkOutput("oor_rd_wr", 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h02C);
        checkOutput("oor_no_alias", 16'h4444, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'd300);
        checkOutput("oor_rd", 16'h0000, 1'b1);

        // reset while READY
        nreset = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h010);
        checkOutput("ready_reset", 16'h0000, 1'b0);
        checkBusy("ready_reset_busy", ClearEn);
        nreset = 1'b1;
`ifdef SAMPLE_RAM_CLEAR_EN
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            idle();
            n++;
        end
        checkCount("sweep2_len", n, 256);
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h010);
        checkOutput("after_reset_cleared", 16'h0000, 1'b1);
`else
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 9'h010);
        checkOutput("after_reset_preserved", 16'hBEEF, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
